// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave):
// decoded opcode and status flags in, mux selects and write enables out.
interface multicycle_control_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath: fetch/decode/execute/memory/writeback.
// Define MCCTRL_JUMP_EN to decode opcode 000010 (j) into the JEX state; otherwise j is illegal.
module multicycle_control (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StRtypeWb = 4'd7,
    StBeqEx   = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJex     = 4'd11
  } state_e;

  state_e state_q;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OpRtype) || (op == OpLw) || (op == OpSw) || (op == OpBeq) || (op == OpAddi);
`ifdef MCCTRL_JUMP_EN
    ok = ok || (op == OpJ);
`endif
    return ok;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:   if (bus.mem_ready) state_q <= StDecode;
        StDecode: begin
          case (bus.op)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StRtypeEx;
            OpBeq:      state_q <= StBeqEx;
            OpAddi:     state_q <= StAddiEx;
`ifdef MCCTRL_JUMP_EN
            OpJ:        state_q <= StJex;
`endif
            default:    state_q <= StFetch;
          endcase
        end
        StMemAdr: begin
          if (bus.op == OpSw)      state_q <= StMemWr;
          else if (bus.op == OpLw) state_q <= StMemRd;
          else                     state_q <= StFetch;
        end
        StMemRd:   if (bus.mem_ready) state_q <= StMemWb;
        StMemWb:   state_q <= StFetch;
        StMemWr:   if (bus.mem_ready) state_q <= StFetch;
        StRtypeEx: state_q <= StRtypeWb;
        StRtypeWb: state_q <= StFetch;
        StBeqEx:   state_q <= StFetch;
        StAddiEx:  state_q <= StAddiWb;
        StAddiWb:  state_q <= StFetch;
        StJex:     state_q <= StFetch;
        default:   state_q <= StFetch;
      endcase
    end
  end

  logic       iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic       pc_write, branch, pc_en, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    state      = state_q;
    case (state_q)
      StFetch: begin
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        illegal   = ~op_legal(bus.op);
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd:   iord = 1'b1;
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StRtypeEx: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRtypeWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBeqEx: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb:  reg_write = 1'b1;
      StJex: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (branch & bus.zero);
    // Reset is asynchronous, so strobes and selects must drop without waiting for a clock edge.
    if (reset) begin
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      illegal    = 1'b0;
      state      = 4'd0;
    end
  end

  assign bus.iord       = iord;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.pc_en      = pc_en;
  assign bus.illegal    = illegal;
  assign bus.state      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: each instruction expands into its list of
// expected states, and per-state outputs come from the control table.
module tb_multicycle_control;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
`ifdef MCCTRL_JUMP_EN
  localparam bit JumpEn = 1'b1;
`else
  localparam bit JumpEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == OpR || op == OpLw || op == OpSw || op == OpBeq || op == OpAddi ||
           (JumpEn && op == OpJ);
  endfunction

  // {iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, src_a, src_b, alu_op, pc_src,
  //  pc_en, illegal}
  function automatic logic [14:0] dut_outs();
    return {bus.iord, bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src, bus.pc_en, bus.illegal};
  endfunction

  function automatic logic [14:0] exp_outs(input int p, input bit mr, input bit z,
                                           input logic [5:0] op);
    logic [14:0] o;
    case (p)
      0:  o = {1'b0, 1'b0, mr,   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, mr,   1'b0};
      1:  o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, !legal(op)};
      2:  o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      3:  o = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4:  o = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      5:  o = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      6:  o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
      7:  o = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      8:  o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, z,    1'b0};
      9:  o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      10: o = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      11: o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
      default: o = '0;
    endcase
    return o;
  endfunction

  // Runs one instruction from FETCH; with mem_ready=1 throughout it takes 2 + path length cycles.
  task automatic run_instr(input logic [5:0] op_v);
    int ph[$];
    ph = {0, 1};
    case (op_v)
      OpR:    ph = {ph, 6, 7};
      OpLw:   ph = {ph, 2, 3, 4};
      OpSw:   ph = {ph, 2, 5};
      OpBeq:  ph = {ph, 8};
      OpAddi: ph = {ph, 9, 10};
      OpJ:    if (JumpEn) ph.push_back(11);
      default: ;
    endcase
    foreach (ph[k]) begin
      int  waits;
      bit  done;
      bit  waitable;
      waits = 0;
      done = 1'b0;
      waitable = (ph[k] == 0 || ph[k] == 3 || ph[k] == 5);
      while (!done) begin
        @(negedge clk);
        if (k == 0) bus.op = op_v;
        bus.zero = 1'($urandom_range(0, 1));
        if (waitable) bus.mem_ready = (waits >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
        else          bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("state", 32'(bus.state), 32'(ph[k]));
        check("outs", 32'(dut_outs()), 32'(exp_outs(ph[k], bus.mem_ready, bus.zero, op_v)));
        done = !waitable || bus.mem_ready;
        waits++;
      end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'd0);
    check({tag, "_outs"}, 32'(dut_outs()), 32'd0);
  endtask

  logic [5:0] ops [8];

  initial begin
    ops = '{OpR, OpLw, OpSw, OpBeq, OpAddi, OpJ, 6'b111111, 6'b010101};
    bus.op = OpR;
    bus.zero = 1'b1;
    bus.mem_ready = 1'b1;
    #12;
    check_reset_outs("reset_hold");

    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("post_reset_state", 32'(bus.state), 32'd0);

    foreach (ops[i]) run_instr(ops[i]);
    for (int n = 0; n < 250; n++) run_instr(ops[$urandom_range(0, 7)]);

    // Abort a store mid-access: mem_write must drop without a clock edge.
    @(negedge clk);
    bus.op = OpSw;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("memwr_state", 32'(bus.state), 32'd5);
    check("memwr_strobe", 32'(bus.mem_write), 32'd1);
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check_reset_outs("async_reset");
    @(negedge clk);
    check_reset_outs("reset_clocked");
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("release_state", 32'(bus.state), 32'd0);

    for (int n = 0; n < 40; n++) run_instr(ops[$urandom_range(0, 7)]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
